// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        HALTED    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DMEM_TIMEOUT_DEF = 64;
    localparam int COUNT_W_DEF      = 32;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use comparator between the load in EX and the instruction in ID.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_write_register,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = (ex_write_register == id_rs);
    assign rt_hit = id_uses_rt && (ex_write_register == id_rt);

    assign load_use = ex_mem_read
                   && (ex_write_register != REG_ZERO)
                   && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_control.sv
// Stall/flush sequencer: load-use, taken branch, data-memory wait,
// memory watchdog and saturating stall-cycle counter.
module pipeline_control
    import pipeline_pkg::*;
#(
    parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
    parameter int COUNT_W      = COUNT_W_DEF
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         idRs,
    input  logic [4:0]         idRt,
    input  logic               idUsesRt,
    input  logic               exMemRead,
    input  logic [4:0]         exWriteRegister,
    input  logic               exBranchTaken,
    input  logic               memMemRead,
    input  logic               memMemWrite,
    input  logic               dmemReady,
    input  logic               haltRequest,
    output logic               pcWrite,
    output logic               ifIdWrite,
    output logic               ifIdFlush,
    output logic               idExWrite,
    output logic               idExBubble,
    output logic               exMemWrite,
    output logic               memWbBubble,
    output logic               dmemRequest,
    output logic               memError,
    output logic               halted,
    output logic [COUNT_W-1:0] stallCycles
);

    localparam int WAIT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DMEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_count;
    logic [WAIT_W-1:0] wait_next;
    logic              error_next;
    logic              load_use;
    logic              access;
    logic              freeze;

    hazard_detect u_hazard (
        .id_rs             (idRs),
        .id_rt             (idRt),
        .id_uses_rt        (idUsesRt),
        .ex_mem_read       (exMemRead),
        .ex_write_register (exWriteRegister),
        .load_use          (load_use)
    );

    assign access = memMemRead | memMemWrite;
    assign halted = (state == HALTED);

    always_comb begin
        state_next = state;
        wait_next  = wait_count;
        error_next = memError;
        freeze     = 1'b0;
        unique case (state)
            RUN: begin
                freeze = access && !dmemReady;
                if (haltRequest) begin
                    state_next = HALTED;
                end else if (freeze) begin
                    state_next = DMEM_WAIT;
                    wait_next  = WAIT_ONE;
                end
            end
            DMEM_WAIT: begin
                freeze = !dmemReady;
                if (dmemReady) begin
                    state_next = RUN;
                    wait_next  = '0;
                end else begin
                    // the entering RUN cycle already counted as wait 1
                    wait_next = wait_count + WAIT_ONE;
                    if (wait_next >= WAIT_MAX) begin
                        error_next = 1'b1;
                        state_next = HALTED;
                    end
                end
            end
            default: begin
                state_next = HALTED;
            end
        endcase
    end

    always_comb begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExWrite   = 1'b1;
        idExBubble  = 1'b0;
        exMemWrite  = 1'b1;
        memWbBubble = 1'b0;
        dmemRequest = access || (state == DMEM_WAIT);
        if (reset || state == HALTED) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            ifIdFlush   = 1'b1;
            idExWrite   = 1'b0;
            idExBubble  = 1'b1;
            exMemWrite  = 1'b0;
            memWbBubble = 1'b1;
            dmemRequest = 1'b0;
        end else if (freeze) begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExWrite   = 1'b0;
            exMemWrite  = 1'b0;
            memWbBubble = 1'b1;
        end else if (exBranchTaken) begin
            // wrong-path ID instruction, so a load-use match is moot
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
        end else if (load_use) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_count  <= '0;
            memError    <= 1'b0;
            stallCycles <= '0;
        end else begin
            state      <= state_next;
            wait_count <= wait_next;
            memError   <= error_next;
            if (!pcWrite && state != HALTED && stallCycles != '1) begin
                stallCycles <= stallCycles + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Randomized + directed bench for pipeline_control against a behavioural model.
module tb_pipeline_control;

    localparam int TO = 4;
    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_HALT = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] idRs, idRt, exWriteRegister;
    logic       idUsesRt, exMemRead, exBranchTaken;
    logic       memMemRead, memMemWrite, dmemReady, haltRequest;

    logic       pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble;
    logic       exMemWrite, memWbBubble, dmemRequest, memError, halted;
    logic [7:0] stallCycles;

    logic       s_pcWrite, s_ifIdWrite, s_ifIdFlush, s_idExWrite;
    logic       s_idExBubble, s_exMemWrite, s_memWbBubble, s_dmemRequest;
    logic       s_memError, s_halted;
    logic [1:0] s_stallCycles;

    int tests = 0;
    int fails = 0;

    int m_mode;
    int m_frozen;
    int m_stall;
    bit m_err;

    always #5 clock = ~clock;

    pipeline_control #(.DMEM_TIMEOUT(TO), .COUNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exWriteRegister(exWriteRegister),
        .exBranchTaken(exBranchTaken),
        .memMemRead(memMemRead), .memMemWrite(memMemWrite),
        .dmemReady(dmemReady), .haltRequest(haltRequest),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExWrite(idExWrite), .idExBubble(idExBubble),
        .exMemWrite(exMemWrite), .memWbBubble(memWbBubble),
        .dmemRequest(dmemRequest), .memError(memError),
        .halted(halted), .stallCycles(stallCycles)
    );

    pipeline_control #(.DMEM_TIMEOUT(TO), .COUNT_W(2)) dut_sat (
        .clock(clock), .reset(reset),
        .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exMemRead(exMemRead), .exWriteRegister(exWriteRegister),
        .exBranchTaken(exBranchTaken),
        .memMemRead(memMemRead), .memMemWrite(memMemWrite),
        .dmemReady(dmemReady), .haltRequest(haltRequest),
        .pcWrite(s_pcWrite), .ifIdWrite(s_ifIdWrite),
        .ifIdFlush(s_ifIdFlush), .idExWrite(s_idExWrite),
        .idExBubble(s_idExBubble), .exMemWrite(s_exMemWrite),
        .memWbBubble(s_memWbBubble), .dmemRequest(s_dmemRequest),
        .memError(s_memError), .halted(s_halted),
        .stallCycles(s_stallCycles)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_in();
        idRs = 0; idRt = 0; idUsesRt = 0;
        exMemRead = 0; exWriteRegister = 0; exBranchTaken = 0;
        memMemRead = 0; memMemWrite = 0; dmemReady = 0; haltRequest = 0;
    endtask

    // One clock: compare at negedge against the model, advance at posedge.
    task automatic step(input string tag);
        bit acc, lu, frz;
        bit e_pc, e_ifid, e_flush, e_idex, e_bub, e_exmem, e_wb, e_req;
        @(negedge clock);
        if (reset) begin
            m_mode = M_RUN; m_frozen = 0; m_err = 0; m_stall = 0;
        end
        acc = memMemRead || memMemWrite;
        lu  = exMemRead && exWriteRegister != 0 &&
              (exWriteRegister == idRs ||
               (idUsesRt && exWriteRegister == idRt));
        frz = !reset && !dmemReady &&
              ((m_mode == M_RUN && acc) || m_mode == M_WAIT);
        e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1;
        e_flush = 0; e_bub = 0; e_wb = 0;
        e_req = acc || m_mode == M_WAIT;
        if (reset || m_mode == M_HALT) begin
            {e_pc, e_ifid, e_idex, e_exmem, e_req} = '0;
            {e_flush, e_bub, e_wb} = '1;
        end else if (frz) begin
            {e_pc, e_ifid, e_idex, e_exmem} = '0;
            e_wb = 1;
        end else if (exBranchTaken) begin
            e_flush = 1; e_bub = 1;
        end else if (lu) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end
        check({tag, ".pcWrite"},     pcWrite,     e_pc);
        check({tag, ".ifIdWrite"},   ifIdWrite,   e_ifid);
        check({tag, ".ifIdFlush"},   ifIdFlush,   e_flush);
        check({tag, ".idExWrite"},   idExWrite,   e_idex);
        check({tag, ".idExBubble"},  idExBubble,  e_bub);
        check({tag, ".exMemWrite"},  exMemWrite,  e_exmem);
        check({tag, ".memWbBubble"}, memWbBubble, e_wb);
        check({tag, ".dmemRequest"}, dmemRequest, e_req);
        check({tag, ".memError"},    memError,    m_err);
        check({tag, ".halted"},      halted,      m_mode == M_HALT);
        check({tag, ".stall"},       stallCycles, (m_stall > 255) ? 255 : m_stall);
        check({tag, ".stall_sat"},   s_stallCycles, (m_stall > 3) ? 3 : m_stall);
        if (!reset) begin
            if (m_mode != M_HALT && !e_pc) m_stall++;
            m_frozen = frz ? m_frozen + 1 : 0;
            if (m_mode == M_RUN && haltRequest) begin
                m_mode = M_HALT;
            end else if (m_mode != M_HALT) begin
                if (m_frozen >= TO) begin
                    m_err = 1; m_mode = M_HALT;
                end else begin
                    m_mode = frz ? M_WAIT : M_RUN;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; clear_in();
        step("rst"); step("rst");
        reset = 0;
    endtask

    initial begin
        m_mode = M_RUN; m_frozen = 0; m_stall = 0; m_err = 0;
        do_reset();

        clear_in(); step("idle");

        // load-use, one bubble
        exMemRead = 1; exWriteRegister = 8; idRs = 8;
        step("lu");
        check("lu_count", stallCycles, 1);
        clear_in(); step("lu_after");

        // destination r0 never stalls
        exMemRead = 1; exWriteRegister = 0; idRs = 0;
        step("r0");
        check("r0_count", stallCycles, 1);

        // three-cycle memory wait then release
        clear_in(); memMemRead = 1;
        repeat (3) step("mwait");
        dmemReady = 1; step("mrel");
        check("mwait_count", stallCycles, 4);
        clear_in(); step("mdone");

        // branch held across a memory wait
        memMemRead = 1; exBranchTaken = 1;
        repeat (2) step("bwait");
        dmemReady = 1; step("brel");
        memMemRead = 0; dmemReady = 0; step("brun");
        check("brun_flush", ifIdFlush, 1);
        clear_in(); step("bdone");

        // watchdog timeout
        do_reset();
        memMemRead = 1;
        repeat (TO) step("tmo");
        check("tmo_err", memError, 1);
        check("tmo_halt", halted, 1);
        dmemReady = 1; step("tmo_late");
        do_reset();
        check("tmo_clr_err", memError, 0);
        check("tmo_clr_halt", halted, 0);

        // reset mid-wait, then counter saturation
        clear_in(); memMemRead = 1;
        repeat (2) step("rwait");
        reset = 1;
        #1;
        check("rst_async_req", dmemRequest, 0);
        check("rst_async_pc", pcWrite, 0);
        step("rst_mid");
        reset = 0; clear_in();
        step("rst_run");
        exMemRead = 1; exWriteRegister = 5; idRt = 5; idUsesRt = 1;
        repeat (5) step("sat");
        check("sat_hold", s_stallCycles, 3);
        clear_in();

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) < 3);
            idRs = 5'($urandom_range(3));
            idRt = 5'($urandom_range(3));
            idUsesRt = 1'($urandom);
            exMemRead = 1'($urandom);
            exWriteRegister = 5'($urandom_range(3));
            exBranchTaken = ($urandom_range(99) < 20);
            memMemRead = ($urandom_range(99) < 25);
            memMemWrite = ($urandom_range(99) < 25);
            dmemReady = ($urandom_range(99) < 60);
            haltRequest = ($urandom_range(99) < 2);
            step("rnd");
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
